// File: rtl/codec_config_seq.sv
// ---------------------------------------------------------------------------
// codec_config_seq
// Walks the fixed 11-entry WM8731 initialisation table and issues one I2C
// register write per entry through the downstream i2c_write block.
// Each entry follows the same pattern: an idle gap, a one-cycle write
// request, then a bounded wait for the completion pulse. The sequence
// ends in DONE when the last entry completes. If a write never completes,
// it ends in ERROR and index keeps the entry that failed.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | after reset; waits for start (or auto-start) to begin
//  GAP       | idle spacing of GAP_CYCLES before each write
//  ISSUE     | i2c_write high for this single cycle; arms the timeout
//  WAIT_DONE | waits for i2c_done, bounded by TIMEOUT_CYCLES
//  NEXT      | one cycle to advance index or finish the table
//  DONE      | sequence complete, config_done sticky; start reruns
//  ERROR     | write timed out, error sticky; start reruns from entry 0
// ---------------------------------------------------------------------------
module codec_config_seq #(
   parameter logic [6:0]  DEV_ADDR       = 7'h1A,
   parameter int unsigned GAP_CYCLES     = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic       start,
   output logic [6:0] i2c_addr,
   output logic [7:0] i2c_register,
   output logic [7:0] i2c_data,
   output logic       i2c_write,
   input  logic       i2c_done,
   output logic       busy,
   output logic       config_done,
   output logic       error,
   output logic [3:0] index
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_GAP       = 3'd1;
   localparam logic [2:0] ST_ISSUE     = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_NEXT      = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;
   localparam logic [2:0] ST_ERROR     = 3'd6;

   localparam logic [3:0] LAST_IDX = 4'd10;

   // The gap and timeout share one down-counter because they never overlap.
   // The counter is sized for the larger of the two, so a load never truncates.
   localparam int unsigned CNT_MAX =
      (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int          CNT_W   = $clog2(CNT_MAX + 1);

   // GAP lasts exactly GAP_CYCLES cycles: load N-1 and leave when the count is 0.
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
   // The ISSUE cycle is the first of the TIMEOUT_CYCLES budget. WAIT_DONE then
   // gets the remaining N-1 cycles, so ERROR appears N cycles after the pulse.
   localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 2);

   logic [2:0]       state_q, state_d;
   logic [3:0]       index_q, index_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             cfg_done_q, cfg_done_d;
   logic             error_q, error_d;
   logic             auto_q;
   logic [7:0]       reg_byte_q, data_byte_q;
   logic [15:0]      entry_d;
   logic             go;

   // Table entry: {register number[6:0], 9-bit value}, which already is
   // {register byte, data byte} in WM8731 wire format.
   function automatic logic [15:0] tbl_entry(input logic [3:0] idx);
      logic [6:0] r;
      logic [8:0] v;
      r = 7'd15;
      v = 9'h000;
      case (idx)
         4'd0:    begin r = 7'd15; v = 9'h000; end
         4'd1:    begin r = 7'd0;  v = 9'h017; end
         4'd2:    begin r = 7'd1;  v = 9'h017; end
         4'd3:    begin r = 7'd2;  v = 9'h079; end
         4'd4:    begin r = 7'd3;  v = 9'h079; end
         4'd5:    begin r = 7'd4;  v = 9'h012; end
         4'd6:    begin r = 7'd5;  v = 9'h000; end
         4'd7:    begin r = 7'd6;  v = 9'h000; end
         4'd8:    begin r = 7'd7;  v = 9'h042; end
         4'd9:    begin r = 7'd8;  v = 9'h000; end
         4'd10:   begin r = 7'd9;  v = 9'h001; end
         default: begin r = 7'd15; v = 9'h000; end
      endcase
      return {r, v};
   endfunction

   // A start request is taken only from the resting states. auto_q is
   // high only in the first cycle after reset, and only when AUTO_START is set.
   assign go = start | auto_q;

   // Next-state and datapath decisions for the sequencer.
   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      cfg_done_d = cfg_done_q;
      error_d    = error_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (go) begin
               state_d    = ST_GAP;
               index_d    = 4'd0;
               cnt_d      = GAP_LOAD;
               busy_d     = 1'b1;
               cfg_done_d = 1'b0;
               error_d    = 1'b0;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_ISSUE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_ISSUE: begin
            cnt_d   = TMO_LOAD;
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            // A done pulse in the same cycle as the timeout still counts as success.
            if (i2c_done) begin
               state_d = ST_NEXT;
            end else if (cnt_q == '0) begin
               state_d = ST_ERROR;
               busy_d  = 1'b0;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_NEXT: begin
            if (index_q == LAST_IDX) begin
               state_d    = ST_DONE;
               busy_d     = 1'b0;
               cfg_done_d = 1'b1;
            end else begin
               index_d = index_q + 4'd1;
               cnt_d   = GAP_LOAD;
               state_d = ST_GAP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Look up the entry for the index being registered, so the register and
   // data bytes change together with index and hold through the write.
   always_comb begin
      entry_d = tbl_entry(index_d);
   end

   // State, counters, sticky flags and registered write payload.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         index_q     <= 4'd0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         cfg_done_q  <= 1'b0;
         error_q     <= 1'b0;
         auto_q      <= AUTO_START;
         reg_byte_q  <= 8'h1E;
         data_byte_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         cfg_done_q  <= cfg_done_d;
         error_q     <= error_d;
         auto_q      <= 1'b0;
         reg_byte_q  <= entry_d[15:8];
         data_byte_q <= entry_d[7:0];
      end
   end

   // The write request is decoded from state, so it can never stay high longer
   // than the single ISSUE cycle. Gating with reset removes it in the cycle
   // where reset is asserted.
   assign i2c_write    = (state_q == ST_ISSUE) & ~reset;
   assign i2c_addr     = DEV_ADDR;
   assign i2c_register = reg_byte_q;
   assign i2c_data     = data_byte_q;
   assign busy         = busy_q;
   assign config_done  = cfg_done_q;
   assign error        = error_q;
   assign index        = index_q;

endmodule

// File: tb/tb_codec_config_seq.sv
// ---------------------------------------------------------------------------
// Testbench for codec_config_seq. It runs two instances: dut_a auto-starts
// after reset, and dut_b waits for an explicit start. Stimulus pushes the
// expected {register, data} pairs into a queue for each instance, and an
// independent monitor pops and compares them on every i2c_write pulse.
// A small completion model answers each write 10 cycles later.
// ---------------------------------------------------------------------------
module tb_codec_config_seq;

   localparam int GAP = 4;
   localparam int TMO = 50;
   localparam int DONE_DLY = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_a, start_a, done_a, a_write, a_busy, a_cfg, a_err;
   logic reset_b, start_b, done_b, b_write, b_busy, b_cfg, b_err;
   logic [6:0] a_addr, b_addr;
   logic [7:0] a_reg, a_data, b_reg, b_data;
   logic [3:0] a_idx, b_idx;

   logic done_mdl_a = 1'b0, spur_a = 1'b0, spur_main_a = 1'b0;
   logic done_mdl_b = 1'b0;
   logic spur_en = 1'b0, drop_en = 1'b0;
   int   cd_a = 0, cd_b = 0, wn_a = 0, since_a = 1000;

   assign done_a = done_mdl_a | spur_a | spur_main_a;
   assign done_b = done_mdl_b;

   codec_config_seq #(.DEV_ADDR(7'h1A), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO),
                      .AUTO_START(1'b1)) dut_a (
      .sys_clk(clk), .reset(reset_a), .start(start_a), .i2c_addr(a_addr),
      .i2c_register(a_reg), .i2c_data(a_data), .i2c_write(a_write),
      .i2c_done(done_a), .busy(a_busy), .config_done(a_cfg), .error(a_err),
      .index(a_idx));

   codec_config_seq #(.DEV_ADDR(7'h1A), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO),
                      .AUTO_START(1'b0)) dut_b (
      .sys_clk(clk), .reset(reset_b), .start(start_b), .i2c_addr(b_addr),
      .i2c_register(b_reg), .i2c_data(b_data), .i2c_write(b_write),
      .i2c_done(done_b), .busy(b_busy), .config_done(b_cfg), .error(b_err),
      .index(b_idx));

   // Hand-computed {register byte, data byte} for each table entry.
   logic [15:0] TBL [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                             16'h0812, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1000,
                             16'h1201};

   logic [15:0] exp_a[$];
   logic [15:0] exp_b[$];
   int          wt_a[$];
   int          wt_b[$];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic push_a(input int n);
      for (int i = 0; i < n; i++) exp_a.push_back(TBL[i]);
   endtask

   task automatic push_b(input int n);
      for (int i = 0; i < n; i++) exp_b.push_back(TBL[i]);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Scoreboard monitor for dut_a.
   initial begin : mon_a
      logic prev;
      logic [15:0] e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (a_write) begin
            chk("a write pulse width", {31'd0, prev}, 32'd0);
            chk("a i2c_addr", {25'd0, a_addr}, 32'h1A);
            if (exp_a.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a unexpected write: got %02h/%02h, expected none", a_reg, a_data);
            end else begin
               e = exp_a.pop_front();
               chk("a register/data", {16'd0, a_reg, a_data}, {16'd0, e});
            end
            wt_a.push_back(cyc);
         end
         prev = a_write;
      end
   end

   // Scoreboard monitor for dut_b.
   initial begin : mon_b
      logic prev;
      logic [15:0] e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (b_write) begin
            chk("b write pulse width", {31'd0, prev}, 32'd0);
            chk("b i2c_addr", {25'd0, b_addr}, 32'h1A);
            if (exp_b.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b unexpected write: got %02h/%02h, expected none", b_reg, b_data);
            end else begin
               e = exp_b.pop_front();
               chk("b register/data", {16'd0, b_reg, b_data}, {16'd0, e});
            end
            wt_b.push_back(cyc);
         end
         prev = b_write;
      end
   end

   // Completion model: pulse done DONE_DLY cycles after each write.
   // When drop_en is set, the 4th write of the run gets no done pulse.
   initial forever begin
      @(negedge clk);
      done_mdl_a = 1'b0;
      if (reset_a) begin
         cd_a = 0;
      end else begin
         if (cd_a != 0) begin
            cd_a--;
            if (cd_a == 0) done_mdl_a = 1'b1;
         end
         if (a_write) begin
            if (!(drop_en && wn_a == 3)) cd_a = DONE_DLY;
            wn_a++;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      done_mdl_b = 1'b0;
      if (reset_b) begin
         cd_b = 0;
      end else begin
         if (cd_b != 0) begin
            cd_b--;
            if (cd_b == 0) done_mdl_b = 1'b1;
         end
         if (b_write) cd_b = DONE_DLY;
      end
   end

   // Spurious done pulses in the ISSUE cycle and at two points inside the
   // following GAP (cycles 12 and 13 after a write).
   initial forever begin
      @(negedge clk);
      if (a_write) since_a = 0;
      else if (since_a < 1000) since_a++;
      spur_a = spur_en && (a_write || since_a == 12 || since_a == 13);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int rel, err_c, c0;
      reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst i2c_write", {31'd0, a_write}, 0);
      chk("rst busy", {31'd0, a_busy}, 0);
      chk("rst config_done", {31'd0, a_cfg}, 0);
      chk("rst error", {31'd0, a_err}, 0);
      chk("rst index", {28'd0, a_idx}, 0);
      chk("rst register", {24'd0, a_reg}, 32'h1E);
      chk("rst data", {24'd0, a_data}, 32'h00);
      chk("rst addr", {25'd0, a_addr}, 32'h1A);

      // 1: auto-start full sequence
      push_a(11);
      wt_a.delete();
      reset_a = 1'b0; reset_b = 1'b0;
      rel = cyc;
      @(negedge clk);
      chk("t1 busy after release", {31'd0, a_busy}, 1);
      for (int i = 0; i < 400 && !a_cfg; i++) @(negedge clk);
      chk("t1 config_done", {31'd0, a_cfg}, 1);
      chk("t1 busy", {31'd0, a_busy}, 0);
      chk("t1 error", {31'd0, a_err}, 0);
      chk("t1 index", {28'd0, a_idx}, 10);
      chk("t1 write count", wt_a.size(), 11);
      chk("t1 pending expected", exp_a.size(), 0);
      if (wt_a.size() >= 2) begin
         chk("t1 first write latency", wt_a[0] - rel, GAP + 1);
         chk("t1 write interval", wt_a[1] - wt_a[0], DONE_DLY + 2 + GAP);
      end

      // 2: done never arrives for entry 3
      reset_a = 1'b1;
      drop_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      wn_a = 0;
      exp_a.delete();
      push_a(4);
      wt_a.delete();
      reset_a = 1'b0;
      for (int i = 0; i < 400 && !a_err; i++) @(negedge clk);
      err_c = cyc;
      chk("t2 error", {31'd0, a_err}, 1);
      chk("t2 busy", {31'd0, a_busy}, 0);
      chk("t2 index", {28'd0, a_idx}, 3);
      chk("t2 config_done", {31'd0, a_cfg}, 0);
      chk("t2 write count", wt_a.size(), 4);
      if (wt_a.size() == 4) chk("t2 timeout latency", err_c - wt_a[3], TMO);
      repeat (60) @(negedge clk);
      chk("t2 no writes after error", wt_a.size(), 4);
      chk("t2 error sticky", {31'd0, a_err}, 1);

      // 3: restart from ERROR
      drop_en = 1'b0;
      push_a(11);
      wt_a.delete();
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("t3 error cleared", {31'd0, a_err}, 0);
      chk("t3 busy", {31'd0, a_busy}, 1);
      chk("t3 index", {28'd0, a_idx}, 0);
      for (int i = 0; i < 400 && !a_cfg; i++) @(negedge clk);
      chk("t3 config_done", {31'd0, a_cfg}, 1);
      chk("t3 error", {31'd0, a_err}, 0);
      chk("t3 write count", wt_a.size(), 11);
      chk("t3 pending expected", exp_a.size(), 0);

      // 4: spurious done in GAP and in the ISSUE cycle
      push_a(11);
      wt_a.delete();
      spur_en = 1'b1;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      spur_main_a = 1'b1;
      repeat (5) @(negedge clk);
      spur_main_a = 1'b0;
      for (int i = 0; i < 400 && !a_cfg; i++) @(negedge clk);
      spur_en = 1'b0;
      chk("t4 config_done", {31'd0, a_cfg}, 1);
      chk("t4 write count", wt_a.size(), 11);
      chk("t4 pending expected", exp_a.size(), 0);
      if (wt_a.size() >= 2) chk("t4 write interval", wt_a[1] - wt_a[0], DONE_DLY + 2 + GAP);

      // 5: reset while waiting on entry 6
      push_a(11);
      wt_a.delete();
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int i = 0; i < 300 && wt_a.size() < 7; i++) @(negedge clk);
      chk("t5 reached entry 6", wt_a.size(), 7);
      repeat (3) @(negedge clk);
      reset_a = 1'b1;
      @(negedge clk);
      chk("t5 write after reset", {31'd0, a_write}, 0);
      chk("t5 index after reset", {28'd0, a_idx}, 0);
      chk("t5 busy after reset", {31'd0, a_busy}, 0);
      chk("t5 register after reset", {24'd0, a_reg}, 32'h1E);
      exp_a.delete();
      push_a(11);
      wt_a.delete();
      @(negedge clk);
      reset_a = 1'b0;
      for (int i = 0; i < 400 && !a_cfg; i++) @(negedge clk);
      chk("t5 config_done", {31'd0, a_cfg}, 1);
      chk("t5 write count", wt_a.size(), 11);
      chk("t5 pending expected", exp_a.size(), 0);

      // 6: AUTO_START=0 instance
      chk("t6 no auto writes", wt_b.size(), 0);
      chk("t6 idle busy", {31'd0, b_busy}, 0);
      push_b(11);
      start_b = 1'b1;
      c0 = cyc;
      repeat (3) @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 200 && wt_b.size() < 3; i++) @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 400 && !b_cfg; i++) @(negedge clk);
      chk("t6 config_done", {31'd0, b_cfg}, 1);
      chk("t6 busy", {31'd0, b_busy}, 0);
      chk("t6 error", {31'd0, b_err}, 0);
      chk("t6 write count", wt_b.size(), 11);
      chk("t6 pending expected", exp_b.size(), 0);
      if (wt_b.size() > 0) chk("t6 first write latency", wt_b[0] - c0, GAP + 1);
      repeat (40) @(negedge clk);
      chk("t6 ran once", wt_b.size(), 11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/codec_config_seq.md
Name: codec_config_seq

Overview:
Upstream sequencer for i2c_write. It walks a fixed 11-entry WM8731 audio-codec initialisation table and issues one register write per entry. It drives i2c_write's addr/register/data/write inputs and consumes its done pulse. It runs once after reset (or on start) and reports completion or timeout.

Parameters:
DEV_ADDR, 7'h1A, 7-bit I2C device address driven on i2c_addr for every entry.
GAP_CYCLES, 1000, sys_clk cycles of idle wait before every write, including the first; minimum 1.
TIMEOUT_CYCLES, 1000000, maximum sys_clk cycles spent waiting for i2c_done before flagging an error; minimum 2.
AUTO_START, 1, 1 = begin the sequence automatically when reset releases.

Ports:
sys_clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  level-sampled request to (re)run the sequence; ignored while busy
i2c_addr  output  7  device address, constant DEV_ADDR
i2c_register  output  8  register byte: {reg_index[6:0], value[8]}
i2c_data  output  8  data byte: value[7:0]
i2c_write  output  1  one-cycle write request to i2c_write
i2c_done  input  1  completion pulse from i2c_write
busy  output  1  high from sequence start until DONE or ERROR
config_done  output  1  sticky; sequence completed successfully
error  output  1  sticky; a write timed out
index  output  4  table entry currently being processed (0..10)

Behaviour:
- Table, in entry order (register: 9-bit value → register byte/data byte):
  - 0: R15 0x000 → 0x1E/0x00
  - 1: R0 0x017 → 0x00/0x17
  - 2: R1 0x017 → 0x02/0x17
  - 3: R2 0x079 → 0x04/0x79
  - 4: R3 0x079 → 0x06/0x79
  - 5: R4 0x012 → 0x08/0x12
  - 6: R5 0x000 → 0x0A/0x00
  - 7: R6 0x000 → 0x0C/0x00
  - 8: R7 0x042 → 0x0E/0x42
  - 9: R8 0x000 → 0x10/0x00
  - 10: R9 0x001 → 0x12/0x01
- i2c_register and i2c_data are registered and reflect table[index].
- They are stable from the ISSUE cycle until the first cycle after i2c_done is seen.
- Reset values: i2c_write=0, busy=0, config_done=0, error=0, index=0; i2c_register/i2c_data = table[0].
- State is IDLE, then:
  - AUTO_START=1: the first cycle after reset deassertion enters GAP with busy=1.
  - AUTO_START=0: stay in IDLE.
- States:
  - IDLE: start=1 → GAP; index←0; busy←1; config_done←0; error←0.
  - GAP: count GAP_CYCLES cycles, then → ISSUE.
  - ISSUE: i2c_write=1 for exactly this one cycle; timeout counter cleared → WAIT_DONE. i2c_write is never held high for 2+ cycles.
  - WAIT_DONE: i2c_write=0.
    - i2c_done=1 → NEXT.
    - Counter reaches TIMEOUT_CYCLES first → ERROR.
    - If done and the timeout coincide in the same cycle, done wins.
  - NEXT (1 cycle):
    - index==10 → DONE.
    - Otherwise index←index+1 → GAP.
  - DONE: busy←0; config_done←1. start=1 → same as IDLE start.
  - ERROR: busy←0; error←1; index holds the failing entry. start=1 → same as IDLE start (restarts from entry 0).
- i2c_done is ignored in every state except WAIT_DONE, including the ISSUE cycle itself.
- start is ignored in GAP, ISSUE, WAIT_DONE and NEXT.
- Mid-operation reset: immediate return to reset values; i2c_write drops the same cycle.
- The GAP before entry 0 gives any in-flight downstream transaction time to finish (i2c_write has no reset).
- Latency, entry k: i2c_write pulses GAP_CYCLES+1 cycles after entering GAP; the next GAP starts 2 cycles after i2c_done is sampled.
- Counters must be wide enough for TIMEOUT_CYCLES (≥20 bits at default); no wrap-around is permitted before the compare.

Test Plan:
All scenarios use GAP_CYCLES=4, TIMEOUT_CYCLES=50, with a bench model that pulses i2c_done 10 cycles after each i2c_write.

1. AUTO_START=1, release reset → exactly 11 single-cycle i2c_write pulses; register/data pairs match table order (0x1E/0x00 … 0x12/0x01); i2c_addr=0x1A; then config_done=1, busy=0, error=0.
2. Model never pulses done on entry 3 → 50 cycles after the 4th write pulse: error=1, busy=0, index=3; no further i2c_write pulses.
3. From ERROR, assert start for 1 cycle → error clears, sequence restarts at index 0, completes with config_done=1.
4. Spurious i2c_done pulses during GAP and during the ISSUE cycle → ignored; index advances only on done seen in WAIT_DONE; all 11 entries still written once.
5. Assert reset while in WAIT_DONE of entry 6 → next cycle: i2c_write=0, index=0, busy=0; after release, full sequence reruns from entry 0.
6. AUTO_START=0 → no writes after reset; start held high 3 cycles → sequence runs exactly once; start pulsed while busy → no effect.
